// File: rtl/limit_ctrl_pkg.sv
// Shared types and widths for the DAC-path limit sequencer.
// Limits and targets are signed 16-bit values; differences use one extra bit.
package limit_ctrl_pkg;

    localparam int LIMIT_W = 16;
    localparam int SIG_W   = 24;
    localparam int DIFF_W  = LIMIT_W + 1;

    typedef enum logic [1:0] {
        LC_IDLE  = 2'd0,
        LC_RAMP  = 2'd1,
        LC_FAULT = 2'd2
    } lc_state_e;

endpackage

// File: rtl/limit_ramp_step.sv
// Combinational next value for one live limit.
// On a tick the limit moves toward its target by at most step; step 0 jumps straight there.
module limit_ramp_step
    import limit_ctrl_pkg::*;
(
    input  logic [LIMIT_W-1:0] cur_i,
    input  logic [LIMIT_W-1:0] tgt_i,
    input  logic [LIMIT_W-1:0] step_i,
    input  logic               tick_i,
    output logic [LIMIT_W-1:0] nxt_o,
    output logic               at_target_o
);

    logic [DIFF_W-1:0] cur_ext;
    logic [DIFF_W-1:0] tgt_ext;
    logic [DIFF_W-1:0] step_ext;
    logic [DIFF_W-1:0] diff;
    logic [DIFF_W-1:0] mag;
    logic [DIFF_W-1:0] moved;

    always_comb begin
        cur_ext  = {cur_i[LIMIT_W-1], cur_i};
        tgt_ext  = {tgt_i[LIMIT_W-1], tgt_i};
        step_ext = {1'b0, step_i};
        // Two's-complement difference; one extra bit covers the full signed span.
        diff     = tgt_ext - cur_ext;
        mag      = diff[DIFF_W-1] ? (~diff + {{(DIFF_W-1){1'b0}}, 1'b1}) : diff;
        moved    = diff[DIFF_W-1] ? (cur_ext - step_ext) : (cur_ext + step_ext);

        nxt_o = cur_i;
        if (tick_i) begin
            if ((step_i == '0) || (mag <= step_ext)) begin
                nxt_o = tgt_i;
            end else begin
                nxt_o = moved[LIMIT_W-1:0];
            end
        end
        at_target_o = (nxt_o == tgt_i);
    end

endmodule

// File: rtl/limit_ramp_ctrl.sv
// Limit sequencer: accepts validated limit pairs, ramps the live limits toward them,
// and collapses both limits to zero on sustained clipping until software clears it.
module limit_ramp_ctrl
    import limit_ctrl_pkg::*;
#(
    parameter int TICK_W = 16,
    parameter int CLIP_W = 16
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic [LIMIT_W-1:0]  cfg_upper,
    input  logic [LIMIT_W-1:0]  cfg_lower,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic                cfg_err,
    input  logic [LIMIT_W-1:0]  step,
    input  logic [TICK_W-1:0]   tick_div,
    input  logic [SIG_W-1:0]    signal_in,
    input  logic [CLIP_W-1:0]   clip_max,
    input  logic                fault_clear,
    output logic [LIMIT_W-1:0]  limit_upper,
    output logic [LIMIT_W-1:0]  limit_lower,
    output logic                busy,
    output logic                fault,
    output logic                clip_active,
    output logic [CLIP_W-1:0]   clip_run
);

    lc_state_e           state_q, state_d;
    logic [LIMIT_W-1:0]  upper_q, upper_d, lower_q, lower_d;
    logic [LIMIT_W-1:0]  tgt_up_q, tgt_up_d, tgt_lo_q, tgt_lo_d;
    logic [TICK_W-1:0]   presc_q, presc_d;
    logic                ready_q, ready_d, err_q, err_d, busy_q, busy_d, fault_q, fault_d;
    logic                clip_act_q, clip_act_d;
    logic [CLIP_W-1:0]   run_q, run_d;

    logic                tick, hs, pair_ok, clip, trig;
    logic [LIMIT_W-1:0]  up_nxt, lo_nxt;
    logic                up_at, lo_at;
    logic [CLIP_W:0]     run_inc;
    logic [SIG_W-1:0]    up_sext, lo_sext;

    assign tick    = (state_q == LC_RAMP) && (presc_q == '0);
    assign hs      = cfg_valid && ready_q;
    assign pair_ok = $signed(cfg_upper) >= $signed(cfg_lower);
    assign up_sext = {{(SIG_W-LIMIT_W){upper_q[LIMIT_W-1]}}, upper_q};
    assign lo_sext = {{(SIG_W-LIMIT_W){lower_q[LIMIT_W-1]}}, lower_q};
    assign clip    = ($signed(signal_in) > $signed(up_sext)) || ($signed(signal_in) < $signed(lo_sext));
    assign run_inc = {1'b0, run_q} + {{CLIP_W{1'b0}}, 1'b1};
    assign trig    = (clip_max != '0) && clip && (run_inc >= {1'b0, clip_max})
                     && (state_q != LC_FAULT);

    limit_ramp_step u_step_upper (
        .cur_i(upper_q), .tgt_i(tgt_up_q), .step_i(step), .tick_i(tick),
        .nxt_o(up_nxt), .at_target_o(up_at)
    );

    limit_ramp_step u_step_lower (
        .cur_i(lower_q), .tgt_i(tgt_lo_q), .step_i(step), .tick_i(tick),
        .nxt_o(lo_nxt), .at_target_o(lo_at)
    );

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q    <= LC_IDLE;
            upper_q    <= '0;
            lower_q    <= '0;
            tgt_up_q   <= '0;
            tgt_lo_q   <= '0;
            presc_q    <= '0;
            ready_q    <= 1'b1;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
            clip_act_q <= 1'b0;
            run_q      <= '0;
        end else begin
            state_q    <= state_d;
            upper_q    <= upper_d;
            lower_q    <= lower_d;
            tgt_up_q   <= tgt_up_d;
            tgt_lo_q   <= tgt_lo_d;
            presc_q    <= presc_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            fault_q    <= fault_d;
            clip_act_q <= clip_act_d;
            run_q      <= run_d;
        end
    end

    // A fault trigger outranks everything, including a same-cycle handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LC_IDLE:  if (trig) state_d = LC_FAULT;
                      else if (hs && pair_ok) state_d = LC_RAMP;
            LC_RAMP:  if (trig) state_d = LC_FAULT;
                      else if (tick && up_at && lo_at) state_d = LC_IDLE;
            LC_FAULT: if (fault_clear) state_d = LC_IDLE;
            default:  state_d = LC_IDLE;
        endcase
    end

    always_comb begin
        upper_d    = upper_q;
        lower_d    = lower_q;
        tgt_up_d   = tgt_up_q;
        tgt_lo_d   = tgt_lo_q;
        presc_d    = presc_q;
        err_d      = 1'b0;
        clip_act_d = clip;
        run_d      = clip ? ((&run_q) ? run_q : run_inc[CLIP_W-1:0]) : '0;

        if (trig) begin
            upper_d  = '0;
            lower_d  = '0;
            tgt_up_d = '0;
            tgt_lo_d = '0;
        end else if (state_q == LC_IDLE) begin
            if (hs && pair_ok) begin
                tgt_up_d = cfg_upper;
                tgt_lo_d = cfg_lower;
                presc_d  = tick_div;
            end else if (hs) begin
                err_d = 1'b1;
            end
        end else if (state_q == LC_RAMP) begin
            presc_d = tick ? tick_div : (presc_q - {{(TICK_W-1){1'b0}}, 1'b1});
            upper_d = up_nxt;
            lower_d = lo_nxt;
        end

        ready_d = (state_d == LC_IDLE);
        busy_d  = (state_d == LC_RAMP);
        fault_d = (state_d == LC_FAULT);
    end

    assign cfg_ready   = ready_q;
    assign cfg_err     = err_q;
    assign busy        = busy_q;
    assign fault       = fault_q;
    assign limit_upper = upper_q;
    assign limit_lower = lower_q;
    assign clip_active = clip_act_q;
    assign clip_run    = run_q;

endmodule

// File: tb/tb_limit_ramp_ctrl.sv
// Directed bench for limit_ramp_ctrl: each step pushes the expected output snapshot,
// clocks once, then pops and compares it against the registered outputs.
module tb_limit_ramp_ctrl;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [15:0] cfg_upper, cfg_lower;
    logic        cfg_valid;
    logic        cfg_ready, cfg_err;
    logic [15:0] step;
    logic [15:0] tick_div;
    logic [23:0] signal_in;
    logic [15:0] clip_max;
    logic        fault_clear;
    logic [15:0] limit_upper, limit_lower;
    logic        busy, fault, clip_active;
    logic [15:0] clip_run;

    int vectors = 0;
    int miscompares = 0;

    logic [52:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    limit_ramp_ctrl #(.TICK_W(16), .CLIP_W(16)) dut (
        .clk(clk), .aresetn(aresetn),
        .cfg_upper(cfg_upper), .cfg_lower(cfg_lower), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err),
        .step(step), .tick_div(tick_div), .signal_in(signal_in),
        .clip_max(clip_max), .fault_clear(fault_clear),
        .limit_upper(limit_upper), .limit_lower(limit_lower),
        .busy(busy), .fault(fault), .clip_active(clip_active), .clip_run(clip_run)
    );

    function automatic logic [52:0] snap(input logic rdy, input logic err, input logic bsy,
                                         input logic flt, input logic ca,
                                         input logic [15:0] up, input logic [15:0] lo,
                                         input logic [15:0] run);
        return {rdy, err, bsy, flt, ca, up, lo, run};
    endfunction

    task automatic chk(input string tag, input logic [52:0] expv);
        logic [52:0] obs;
        logic [52:0] want;
        string       t;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        obs  = {cfg_ready, cfg_err, busy, fault, clip_active, limit_upper, limit_lower, clip_run};
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        vectors++;
        $display("step %-14s rdy=%0b err=%0b busy=%0b fault=%0b clip=%0b up=%0d lo=%0d run=%0d",
                 t, cfg_ready, cfg_err, busy, fault, clip_active,
                 $signed(limit_upper), $signed(limit_lower), clip_run);
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", t, obs, want);
        end
    endtask

    // Ordering of the live limits must never invert.
    always @(negedge clk) begin
        if (aresetn === 1'b1) begin
            vectors++;
            assert ($signed(limit_upper) >= $signed(limit_lower)) else begin
                miscompares++;
                $error("FAIL invariant observed up=%0d lo=%0d expected up>=lo",
                       $signed(limit_upper), $signed(limit_lower));
            end
        end
    end

    initial begin
        aresetn = 1'b0; cfg_upper = '0; cfg_lower = '0; cfg_valid = 1'b0;
        step = '0; tick_div = '0; signal_in = '0; clip_max = '0; fault_clear = 1'b0;

        // Reset, then a 300-per-tick ramp to +/-1000.
        chk("reset", snap(1, 0, 0, 0, 0, 16'd0, 16'd0, 16'd0));
        aresetn = 1'b1;
        cfg_upper = 16'd1000; cfg_lower = 16'(-1000); cfg_valid = 1'b1;
        step = 16'd300; tick_div = 16'd0;
        chk("accept", snap(0, 0, 1, 0, 0, 16'd0, 16'd0, 16'd0));
        cfg_valid = 1'b0;
        chk("ramp300", snap(0, 0, 1, 0, 0, 16'd300, 16'(-300), 16'd0));
        chk("ramp600", snap(0, 0, 1, 0, 0, 16'd600, 16'(-600), 16'd0));
        chk("ramp900", snap(0, 0, 1, 0, 0, 16'd900, 16'(-900), 16'd0));
        chk("ramp1000", snap(1, 0, 0, 0, 0, 16'd1000, 16'(-1000), 16'd0));

        // Inverted pair is rejected with a one-cycle error pulse.
        cfg_upper = 16'(-5); cfg_lower = 16'd5; cfg_valid = 1'b1;
        chk("reject", snap(1, 1, 0, 0, 0, 16'd1000, 16'(-1000), 16'd0));
        cfg_valid = 1'b0;
        chk("reject_end", snap(1, 0, 0, 0, 0, 16'd1000, 16'(-1000), 16'd0));

        // Prescaler 3 with step 0: a single jump four cycles after RAMP entry.
        cfg_upper = 16'd20000; cfg_lower = 16'(-20000); cfg_valid = 1'b1;
        step = 16'd0; tick_div = 16'd3;
        chk("jump_accept", snap(0, 0, 1, 0, 0, 16'd1000, 16'(-1000), 16'd0));
        cfg_valid = 1'b0;
        for (int i = 0; i < 3; i++)
            chk("jump_wait", snap(0, 0, 1, 0, 0, 16'd1000, 16'(-1000), 16'd0));
        chk("jump_done", snap(1, 0, 0, 0, 0, 16'd20000, 16'(-20000), 16'd0));

        // Fault after three consecutive clip cycles at +/-100.
        cfg_upper = 16'd100; cfg_lower = 16'(-100); cfg_valid = 1'b1;
        tick_div = 16'd0; clip_max = 16'd3;
        chk("lim100_acc", snap(0, 0, 1, 0, 0, 16'd20000, 16'(-20000), 16'd0));
        cfg_valid = 1'b0;
        chk("lim100", snap(1, 0, 0, 0, 0, 16'd100, 16'(-100), 16'd0));
        signal_in = 24'd150;
        chk("clip1", snap(1, 0, 0, 0, 1, 16'd100, 16'(-100), 16'd1));
        chk("clip2", snap(1, 0, 0, 0, 1, 16'd100, 16'(-100), 16'd2));
        chk("clip3_fault", snap(0, 0, 0, 1, 1, 16'd0, 16'd0, 16'd3));
        signal_in = 24'd0;
        chk("fault_hold", snap(0, 0, 0, 1, 0, 16'd0, 16'd0, 16'd0));
        fault_clear = 1'b1;
        chk("fault_clr", snap(1, 0, 0, 0, 0, 16'd0, 16'd0, 16'd0));
        fault_clear = 1'b0;

        // Two-cycle burst then in-range: no fault.
        cfg_upper = 16'd100; cfg_lower = 16'(-100); cfg_valid = 1'b1;
        chk("burst_acc", snap(0, 0, 1, 0, 0, 16'd0, 16'd0, 16'd0));
        cfg_valid = 1'b0;
        chk("burst_lim", snap(1, 0, 0, 0, 0, 16'd100, 16'(-100), 16'd0));
        signal_in = 24'(-150);
        chk("burst1", snap(1, 0, 0, 0, 1, 16'd100, 16'(-100), 16'd1));
        chk("burst2", snap(1, 0, 0, 0, 1, 16'd100, 16'(-100), 16'd2));
        signal_in = 24'd50;
        chk("burst_end", snap(1, 0, 0, 0, 0, 16'd100, 16'(-100), 16'd0));

        // Fault during a ramp aborts it; clear, then ramp again from zero.
        cfg_upper = 16'd5000; cfg_lower = 16'(-5000); cfg_valid = 1'b1; step = 16'd100;
        chk("mr_accept", snap(0, 0, 1, 0, 0, 16'd100, 16'(-100), 16'd0));
        cfg_valid = 1'b0; signal_in = 24'd20000;
        chk("mr_clip1", snap(0, 0, 1, 0, 1, 16'd200, 16'(-200), 16'd1));
        chk("mr_clip2", snap(0, 0, 1, 0, 1, 16'd300, 16'(-300), 16'd2));
        chk("mr_fault", snap(0, 0, 0, 1, 1, 16'd0, 16'd0, 16'd3));
        signal_in = 24'd0; fault_clear = 1'b1;
        chk("mr_clear", snap(1, 0, 0, 0, 0, 16'd0, 16'd0, 16'd0));
        fault_clear = 1'b0;
        cfg_upper = 16'd50; cfg_lower = 16'(-50); cfg_valid = 1'b1; step = 16'd0;
        chk("mr_re_acc", snap(0, 0, 1, 0, 0, 16'd0, 16'd0, 16'd0));
        cfg_valid = 1'b0;
        chk("mr_re_done", snap(1, 0, 0, 0, 0, 16'd50, 16'(-50), 16'd0));

        // Reset mid-ramp restores everything and the ramp does not resume.
        cfg_upper = 16'd3000; cfg_lower = 16'(-3000); cfg_valid = 1'b1; step = 16'd1000;
        chk("rst_acc", snap(0, 0, 1, 0, 0, 16'd50, 16'(-50), 16'd0));
        cfg_valid = 1'b0;
        chk("rst_ramp", snap(0, 0, 1, 0, 0, 16'd1050, 16'(-1050), 16'd0));
        aresetn = 1'b0;
        chk("rst_mid", snap(1, 0, 0, 0, 0, 16'd0, 16'd0, 16'd0));
        aresetn = 1'b1;
        chk("rst_idle", snap(1, 0, 0, 0, 0, 16'd0, 16'd0, 16'd0));

        // Handshake on the fault-trigger cycle: fault wins, no error pulse.
        cfg_upper = 16'd100; cfg_lower = 16'(-100); cfg_valid = 1'b1; step = 16'd0;
        clip_max = 16'd2;
        chk("co_acc", snap(0, 0, 1, 0, 0, 16'd0, 16'd0, 16'd0));
        cfg_valid = 1'b0;
        chk("co_lim", snap(1, 0, 0, 0, 0, 16'd100, 16'(-100), 16'd0));
        signal_in = 24'd150;
        chk("co_clip1", snap(1, 0, 0, 0, 1, 16'd100, 16'(-100), 16'd1));
        cfg_upper = 16'd2000; cfg_lower = 16'(-2000); cfg_valid = 1'b1;
        chk("co_fault", snap(0, 0, 0, 1, 1, 16'd0, 16'd0, 16'd2));
        cfg_valid = 1'b0; signal_in = 24'd0; fault_clear = 1'b1;
        chk("co_clear", snap(1, 0, 0, 0, 0, 16'd0, 16'd0, 16'd0));
        fault_clear = 1'b0;
        chk("co_idle", snap(1, 0, 0, 0, 0, 16'd0, 16'd0, 16'd0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
